// File: rtl/switch_matrix_cfg_pkg.sv
// Shared types and constants for the routing switch matrix configuration block.
package switch_matrix_pkg;

    // Error reported by the last rejected write or failed commit.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_SELF  = 2'd2,
        ERR_PAIR  = 2'd3
    } err_code_t;

    // Commit sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VALIDATE = 2'd1,
        APPLY    = 2'd2
    } state_t;

    // Driver index reserved for "track not driven".
    localparam int UNDRIVEN = 0;

endpackage

// File: rtl/switch_matrix_cfg_if.sv
// Configuration / status bus between the configuration controller and the matrix.
interface switch_matrix_cfg_if
    import switch_matrix_pkg::*;
#(
    parameter int N_WIRES = 18,
    parameter int SEL_W   = $clog2(N_WIRES + 1)
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_wire_idx;
    logic [SEL_W-1:0] cfg_sel;
    logic             cfg_commit;
    logic             cfg_clear;
    logic             busy;
    logic             err_flag;
    err_code_t        err_code;
    logic [SEL_W-1:0] rb_idx;
    logic [SEL_W-1:0] rb_sel;

    modport master (
        output cfg_valid, cfg_wire_idx, cfg_sel, cfg_commit, cfg_clear, rb_idx,
        input  cfg_ready, busy, err_flag, err_code, rb_sel
    );

    modport slave (
        input  cfg_valid, cfg_wire_idx, cfg_sel, cfg_commit, cfg_clear, rb_idx,
        output cfg_ready, busy, err_flag, err_code, rb_sel
    );
endinterface

// File: rtl/switch_matrix_cfg_mux.sv
// One routing track: selects its driver from the sampled tracks, or stays tri-stated.
module switch_matrix_mux
    import switch_matrix_pkg::*;
#(
    parameter int N_WIRES = 18,
    parameter int SEL_W   = $clog2(N_WIRES + 1)
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic [N_WIRES-1:0] wire_in,
    output logic               wire_out,
    output logic               wire_oe
);
    // Bit 0 is a constant 0 so index 0 (undriven) naturally yields a quiet output.
    logic [N_WIRES:0] padded;

    // Driver selection is purely combinational from the active index.
    always_comb begin
        padded   = {wire_in, 1'b0};
        wire_oe  = (sel != SEL_W'(UNDRIVEN));
        wire_out = padded[sel];
    end
endmodule

// File: rtl/switch_matrix_cfg.sv
// Switch matrix with run-time configuration: shadow table written over the bus,
// validated for self/pair loops on commit, then copied to the active table.
module switch_matrix_cfg
    import switch_matrix_pkg::*;
#(
    parameter int N_WIRES = 18,
    parameter int SEL_W   = $clog2(N_WIRES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    switch_matrix_cfg_if.slave bus,
    input  logic [N_WIRES-1:0] wire_in,
    output logic [N_WIRES-1:0] wire_out,
    output logic [N_WIRES-1:0] wire_oe
);
    localparam logic [SEL_W-1:0] N_SEL    = SEL_W'(N_WIRES);
    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(UNDRIVEN);

    state_t           state_reg, state_next;
    // Entry 0 is never written and stays 0, which keeps index arithmetic simple.
    logic [SEL_W-1:0] shadow_reg [0:N_WIRES];
    logic [SEL_W-1:0] active_reg [0:N_WIRES];
    logic [SEL_W-1:0] chk_idx_reg;
    err_code_t        err_code_reg;
    logic             err_flag_reg;
    logic [SEL_W-1:0] rb_sel_reg;

    logic             idle;
    logic             range_bad;
    logic             self_bad;
    logic             wr_fire;
    logic [SEL_W-1:0] chk_sel;
    logic             pair_loop;
    logic             chk_last;

    // Write qualification and the per-entry loop check for the validation walk.
    always_comb begin
        range_bad = (bus.cfg_wire_idx == SEL_NONE) || (bus.cfg_wire_idx > N_SEL)
                    || (bus.cfg_sel > N_SEL);
        self_bad  = (bus.cfg_sel == bus.cfg_wire_idx);
        chk_sel   = shadow_reg[chk_idx_reg];
        pair_loop = (chk_sel != SEL_NONE) && (shadow_reg[chk_sel] == chk_idx_reg);
        chk_last  = (chk_idx_reg == N_SEL);
    end

    // Next state and handshake outputs; requests are only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        idle       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                idle = 1'b1;
                if (bus.cfg_commit) state_next = VALIDATE;
            end
            VALIDATE: begin
                if (pair_loop)     state_next = IDLE;
                else if (chk_last) state_next = APPLY;
            end
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        wr_fire = bus.cfg_valid && idle;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Validation walk index: restarts at track 1 whenever idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        chk_idx_reg <= SEL_W'(1);
        else if (state_reg == VALIDATE) chk_idx_reg <= chk_idx_reg + SEL_W'(1);
        else                            chk_idx_reg <= SEL_W'(1);
    end

    // Shadow table and error status; a same-cycle write overrides clear for its entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= N_WIRES; k++) shadow_reg[k] <= '0;
            err_code_reg <= ERR_NONE;
            err_flag_reg <= 1'b0;
        end else begin
            if (idle && bus.cfg_clear) begin
                for (int k = 0; k <= N_WIRES; k++) shadow_reg[k] <= '0;
            end
            if (wr_fire) begin
                if (range_bad) begin
                    err_code_reg <= ERR_RANGE;
                    err_flag_reg <= 1'b1;
                end else if (self_bad) begin
                    err_code_reg <= ERR_SELF;
                    err_flag_reg <= 1'b1;
                end else begin
                    shadow_reg[bus.cfg_wire_idx] <= bus.cfg_sel;
                    err_code_reg <= ERR_NONE;
                    err_flag_reg <= 1'b0;
                end
            end
            if (state_reg == VALIDATE && pair_loop) begin
                err_code_reg <= ERR_PAIR;
                err_flag_reg <= 1'b1;
            end
            if (state_reg == APPLY) begin
                err_code_reg <= ERR_NONE;
                err_flag_reg <= 1'b0;
            end
        end
    end

    // Active table: whole shadow copied in the single APPLY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= N_WIRES; k++) active_reg[k] <= '0;
        end else if (state_reg == APPLY) begin
            for (int k = 0; k <= N_WIRES; k++) active_reg[k] <= shadow_reg[k];
        end
    end

    // Registered readback of the active driver; out-of-range indices read as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   rb_sel_reg <= '0;
        else if (bus.rb_idx > N_SEL) rb_sel_reg <= '0;
        else                       rb_sel_reg <= active_reg[bus.rb_idx];
    end

    assign bus.cfg_ready = idle;
    assign bus.busy      = !idle;
    assign bus.err_flag  = err_flag_reg;
    assign bus.err_code  = err_code_reg;
    assign bus.rb_sel    = rb_sel_reg;

    // One driver mux per track; track gi maps to bit gi-1.
    for (genvar gi = 1; gi <= N_WIRES; gi++) begin : g_track
        switch_matrix_mux #(
            .N_WIRES (N_WIRES),
            .SEL_W   (SEL_W)
        ) u_mux (
            .sel      (active_reg[gi]),
            .wire_in  (wire_in),
            .wire_out (wire_out[gi-1]),
            .wire_oe  (wire_oe[gi-1])
        );
    end
endmodule

// File: tb/tb_switch_matrix_cfg.sv
// Scoreboard bench: stimulus queues expected values tagged with the cycle they
// must hold in; a negedge monitor pops and compares them against the DUT.
module tb_switch_matrix_cfg;
    import switch_matrix_pkg::*;

    localparam int N  = 18;
    localparam int SW = $clog2(N + 1);

    localparam int F_OE    = 0;
    localparam int F_OUT   = 1;
    localparam int F_BUSY  = 2;
    localparam int F_FLAG  = 3;
    localparam int F_CODE  = 4;
    localparam int F_RB    = 5;
    localparam int F_READY = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] wire_in;
    logic [N-1:0] wire_out;
    logic [N-1:0] wire_oe;

    switch_matrix_cfg_if #(.N_WIRES(N), .SEL_W(SW)) bus();

    switch_matrix_cfg #(.N_WIRES(N), .SEL_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .wire_in  (wire_in),
        .wire_out (wire_out),
        .wire_oe  (wire_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          cyc;
        int          field;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Queue an expectation dly cycles from now, keeping the queue ordered by cycle.
    function automatic void expect_at(string name, int field, int dly, logic [31:0] exp);
        sb_item_t it;
        int pos;
        it.name  = name;
        it.cyc   = cyc + dly;
        it.field = field;
        it.exp   = exp;
        pos = sb_q.size();
        while (pos > 0 && sb_q[pos-1].cyc > it.cyc) pos--;
        sb_q.insert(pos, it);
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        sb_item_t    it;
        logic [31:0] act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            it = sb_q.pop_front();
            case (it.field)
                F_OE:    act = 32'(wire_oe);
                F_OUT:   act = 32'(wire_out);
                F_BUSY:  act = 32'(bus.busy);
                F_FLAG:  act = 32'(bus.err_flag);
                F_CODE:  act = 32'(bus.err_code);
                F_RB:    act = 32'(bus.rb_sel);
                default: act = 32'(bus.cfg_ready);
            endcase
            checks++;
            if (it.cyc != cyc || act !== it.exp) begin
                errors++;
                $display("FAIL %s: actual %0h required %0h (cycle %0d, due %0d)",
                         it.name, act, it.exp, cyc, it.cyc);
            end else begin
                $display("check %s ok: %0h (cycle %0d)", it.name, act, cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int idx, input int sel);
        bus.cfg_valid    = 1'b1;
        bus.cfg_wire_idx = SW'(idx);
        bus.cfg_sel      = SW'(sel);
        tick();
        bus.cfg_valid    = 1'b0;
    endtask

    task automatic do_commit();
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.cfg_valid    = 1'b0;
        bus.cfg_wire_idx = '0;
        bus.cfg_sel      = '0;
        bus.cfg_commit   = 1'b0;
        bus.cfg_clear    = 1'b0;
        bus.rb_idx       = '0;
        wire_in          = 18'h2A5C3;
        tick(2);
        rst = 1'b0;

        // Reset state
        expect_at("rst_oe",    F_OE,    0, 32'h0);
        expect_at("rst_out",   F_OUT,   0, 32'h0);
        expect_at("rst_busy",  F_BUSY,  0, 32'h0);
        expect_at("rst_flag",  F_FLAG,  0, 32'h0);
        expect_at("rst_code",  F_CODE,  0, 32'h0);
        expect_at("rst_rb",    F_RB,    0, 32'h0);
        expect_at("rst_ready", F_READY, 0, 32'h1);
        tick();

        // 1: track 3 driven from track 7, commit latency of N+1 busy cycles
        do_write(3, 7);
        expect_at("t1_wr_flag", F_FLAG, 0, 32'h0);
        do_commit();
        expect_at("t1_ready_busy", F_READY, 0, 32'h0);
        for (int k = 0; k <= N; k++) expect_at("t1_busy", F_BUSY, k, 32'h1);
        expect_at("t1_busy_end", F_BUSY, N + 1, 32'h0);
        expect_at("t1_oe_old",   F_OE,   N,     32'h0);
        expect_at("t1_oe_new",   F_OE,   N + 1, 32'h4);
        tick(N + 1);
        wire_in = 18'h00040;
        expect_at("t1_out_hi", F_OUT, 0, 32'h4);
        tick();
        wire_in = 18'h3FFBF;
        expect_at("t1_out_lo", F_OUT, 0, 32'h0);
        tick();
        bus.rb_idx = SW'(3);
        tick();
        expect_at("t1_rb3", F_RB, 0, 32'h7);
        bus.rb_idx = SW'(0);
        tick();
        expect_at("t1_rb0", F_RB, 0, 32'h0);
        bus.rb_idx = SW'(20);
        tick();
        expect_at("t1_rb20", F_RB, 0, 32'h0);
        bus.rb_idx = SW'(3);

        // 2: self loop rejected, empty commit succeeds and clears the error
        do_reset();
        expect_at("t2_rst_oe", F_OE, 0, 32'h0);
        do_write(5, 5);
        expect_at("t2_self_code", F_CODE, 0, 32'h2);
        expect_at("t2_self_flag", F_FLAG, 0, 32'h1);
        do_commit();
        expect_at("t2_oe",   F_OE,   N + 1, 32'h0);
        expect_at("t2_flag", F_FLAG, N + 1, 32'h0);
        expect_at("t2_code", F_CODE, N + 1, 32'h0);
        tick(N + 1);

        // 3: pair loop 4<->9 aborts at i=4, active keeps 3<-7
        do_write(3, 7);
        do_commit();
        expect_at("t3_base_oe", F_OE, N + 1, 32'h4);
        tick(N + 1);
        do_write(4, 9);
        do_write(9, 4);
        expect_at("t3_wr_flag", F_FLAG, 0, 32'h0);
        do_commit();
        expect_at("t3_busy_i3",  F_BUSY,  3, 32'h1);
        expect_at("t3_code_i3",  F_CODE,  3, 32'h0);
        expect_at("t3_busy_end", F_BUSY,  4, 32'h0);
        expect_at("t3_code",     F_CODE,  4, 32'h3);
        expect_at("t3_flag",     F_FLAG,  4, 32'h1);
        expect_at("t3_oe_kept",  F_OE,    4, 32'h4);
        expect_at("t3_ready",    F_READY, 4, 32'h1);
        tick(4);

        // 4: range errors leave the shadow alone; a good write clears the error
        do_write(0, 1);
        expect_at("t4_idx0_code", F_CODE, 0, 32'h1);
        expect_at("t4_idx0_flag", F_FLAG, 0, 32'h1);
        do_write(19, 1);
        expect_at("t4_idx19_code", F_CODE, 0, 32'h1);
        do_write(2, 19);
        expect_at("t4_sel19_code", F_CODE, 0, 32'h1);
        do_write(4, 0);
        expect_at("t4_ok_flag", F_FLAG, 0, 32'h0);
        expect_at("t4_ok_code", F_CODE, 0, 32'h0);
        do_write(9, 0);
        do_commit();
        expect_at("t4_oe", F_OE, N + 1, 32'h4);
        tick(N + 1);

        // 5: requests during busy are ignored; reset mid-VALIDATE is immediate
        do_write(8, 2);
        do_commit();
        tick(2);
        bus.cfg_valid    = 1'b1;
        bus.cfg_wire_idx = SW'(6);
        bus.cfg_sel      = SW'(1);
        bus.cfg_commit   = 1'b1;
        bus.cfg_clear    = 1'b1;
        expect_at("t5_ready_busy", F_READY, 0, 32'h0);
        expect_at("t5_busy_mid",   F_BUSY,  0, 32'h1);
        tick();
        bus.cfg_valid  = 1'b0;
        bus.cfg_commit = 1'b0;
        bus.cfg_clear  = 1'b0;
        expect_at("t5_busy_last", F_BUSY, 15, 32'h1);
        expect_at("t5_busy_end",  F_BUSY, 16, 32'h0);
        expect_at("t5_oe",        F_OE,   16, 32'h84);
        expect_at("t5_flag",      F_FLAG, 16, 32'h0);
        tick(16);
        expect_at("t5_rb_pre", F_RB, 0, 32'h7);
        do_commit();
        tick(2);
        #2;
        rst = 1'b1;
        expect_at("t5_arst_oe",    F_OE,    0, 32'h0);
        expect_at("t5_arst_out",   F_OUT,   0, 32'h0);
        expect_at("t5_arst_busy",  F_BUSY,  0, 32'h0);
        expect_at("t5_arst_ready", F_READY, 0, 32'h1);
        expect_at("t5_arst_rb",    F_RB,    0, 32'h0);
        tick(2);
        rst = 1'b0;

        // 6: clear and write 2<-1 in the same cycle, only track 2 survives
        do_write(5, 8);
        do_write(7, 1);
        bus.cfg_clear = 1'b1;
        do_write(2, 1);
        bus.cfg_clear = 1'b0;
        do_commit();
        expect_at("t6_oe", F_OE, N + 1, 32'h2);
        tick(N + 1);
        wire_in = 18'h00001;
        expect_at("t6_out_hi", F_OUT, 0, 32'h2);
        tick();
        wire_in = 18'h3FFFE;
        expect_at("t6_out_lo", F_OUT, 0, 32'h0);
        tick(3);

        if (sb_q.size() != 0) begin
            errors += sb_q.size();
            $display("FAIL scoreboard_drain: actual %0d pending required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_matrix_cfg.md
Name: switch_matrix_cfg

Overview:
- Parametrised routing switch matrix for the FPGA fabric. N_WIRES routing tracks, each optionally driven by one other track selected by a per-track driver index; index 0 means undriven (tri-state).
- Replaces fixed, initial-block driver tables with a run-time write port, a shadow/active double buffer, and a commit step. The commit step walks the table and rejects loops before they reach the fabric.
- Sits between the configuration controller and the tile's routing wires. Bidirectional tracks are split into separate in, out and output-enable vectors; the pad/tile wrapper resolves them to inout.

Parameters:
- N_WIRES, 18, number of routing tracks (2..255).
- SEL_W, $clog2(N_WIRES+1), driver index width; value 0 reserved for undriven.

Ports:
- clk  in  1  fabric configuration clock
- rst  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  write request
- cfg_ready  out  1  write/commit/clear accepted this cycle
- cfg_wire_idx  in  SEL_W  track being configured (1..N_WIRES)
- cfg_sel  in  SEL_W  driver track for cfg_wire_idx (0..N_WIRES)
- cfg_commit  in  1  pulse: validate shadow, then apply to active
- cfg_clear  in  1  pulse: zero the shadow table
- busy  out  1  commit in progress
- err_flag  out  1  sticky error
- err_code  out  2  0 none, 1 range, 2 self-loop, 3 pair-loop
- rb_idx  in  SEL_W  readback track index
- rb_sel  out  SEL_W  active driver of rb_idx, registered
- wire_in  in  N_WIRES  sampled track values, bit i-1 = track i
- wire_out  out  N_WIRES  driven values
- wire_oe  out  N_WIRES  output enables

Behaviour:
- Reset (async, immediate): shadow and active tables all 0. wire_oe=0, wire_out=0, busy=0, err_flag=0, err_code=0, rb_sel=0, FSM=IDLE.
- Data path is combinational from the registered active table.
  - wire_oe[i-1] = (active[i]!=0).
  - wire_out[i-1] = oe ? wire_in[active[i]-1] : 0.
- cfg_ready = (state==IDLE). A write is accepted on cfg_valid && cfg_ready.
  - cfg_wire_idx==0, cfg_wire_idx>N_WIRES or cfg_sel>N_WIRES: write dropped, err_code=1.
  - cfg_sel==cfg_wire_idx: write dropped, err_code=2.
  - Otherwise shadow[idx]=sel on the next edge.
- Any error sets err_flag (sticky). err_flag and err_code clear on the next successful write or successful commit.
- cfg_clear in IDLE zeroes all shadow entries in 1 cycle. If cfg_valid arrives in the same cycle, the write wins for its entry.
- cfg_commit in IDLE: if cfg_valid arrives in the same cycle, the write is applied first and validation sees it.
- FSM:
  - IDLE --cfg_commit--> VALIDATE, with i=1.
  - VALIDATE checks one entry per cycle. Pair loop means s=shadow[i], s!=0 and shadow[s]==i.
    - Loop found: go to IDLE, err_code=3, err_flag=1, active unchanged.
    - i==N_WIRES and no loop: go to APPLY.
  - APPLY copies shadow to active in 1 cycle, then returns to IDLE.
- busy=1 in VALIDATE and APPLY. cfg_commit, cfg_clear and cfg_valid are ignored while busy; no error is raised for ignored requests.
- Commit latency: commit seen at edge t, VALIDATE occupies N_WIRES cycles, APPLY edge is t+N_WIRES+1. The new wire_oe/wire_out are visible after that edge.
- Loops longer than 2 are not detected. The configuration controller is responsible for them.
- rb_sel = active[rb_idx] registered, 1-cycle latency. rb_idx out of range returns 0.
- Reset asserted mid-commit aborts: active returns to 0, the whole table is lost.

Decomposition:
- Package switch_matrix_pkg holds:
  - err_code enum: ERR_NONE, ERR_RANGE, ERR_SELF, ERR_PAIR.
  - FSM state enum: IDLE, VALIDATE, APPLY.
  - UNDRIVEN=0 constant.
- One sub-module, switch_matrix_mux: one per track, instantiated by generate. Inputs: active index and wire_in. Outputs: wire_out bit and wire_oe bit.

Test Plan:
1. Reset, then write idx=3 sel=7 and commit with N=18. Expect busy for 19 cycles, then wire_oe=bit2 only and wire_out[2] tracking wire_in[6]. rb_idx=3 gives rb_sel=7 one cycle later.
2. Write idx=5 sel=5. Expect write dropped, err_code=2, err_flag=1. A commit then leaves active all 0.
3. Write 4<-9 and 9<-4, then commit. Expect err_code=3 after VALIDATE reaches i=4. Active keeps the previous configuration; wire_oe unchanged.
4. Write idx=0 sel=1, then idx=19 sel=1. Expect err_code=1 after each, shadow unchanged. A following valid write clears err_flag.
5. Assert cfg_valid and cfg_commit during busy. Expect cfg_ready=0, no table change, commit not restarted. Assert rst mid-VALIDATE: all outputs 0 immediately, asynchronously.
6. Same-cycle cfg_clear with write 2<-1, then commit. Expect only track 2 enabled, driven from wire_in[0].
